// File: rtl/img_pkg.sv
// Shared types and helpers for the line-buffered vertical window generator.
package img_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_STREAM,
        ST_DONE
    } state_t;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Line RAM feeding window tap 'tap' (0 = oldest) when 'wr_ptr' holds the oldest line.
    function automatic int tap_ram_idx(input int wr_ptr, input int tap, input int nram);
        return (wr_ptr + tap) % nram;
    endfunction

endpackage

// File: rtl/img_line_ram.sv
// Simple dual-port line RAM with registered read and read-before-write.
module img_line_ram
    import img_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int WIDTH = 16
) (
    input  logic                    cmos_pclk,
    input  logic                    wr_en,
    input  logic [cnt_w(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    rd_en,
    input  logic [cnt_w(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]        rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array is deliberately left without reset so it maps onto block RAM;
    // non-blocking updates make a same-address read return the old word.
    always_ff @(posedge cmos_pclk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/img_line_window.sv
// Streaming NUM_LINES-high vertical pixel window built from NUM_LINES-1 line RAMs.
// Build option: IMG_LINEWIN_BORDER_REPLICATE_EN emits from row 0 with top-border replication.
module img_line_window
    import img_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int IMG_COL   = 512,
    parameter int IMG_ROW   = 8,
    parameter int NUM_LINES = 3
) (
    input  logic                          cmos_pclk,
    input  logic                          rst_n,
    input  logic                          frame_valid,
    input  logic [DATA_W-1:0]             pix_in,
    input  logic                          pix_en,
    output logic [NUM_LINES*DATA_W-1:0]   win_data,
    output logic                          win_valid,
    output logic [$clog2(IMG_COL)-1:0]    win_col,
    output logic [$clog2(IMG_ROW)-1:0]    win_row,
    output logic                          win_sol,
    output logic                          win_eol,
    output logic                          win_eof,
    output logic                          frame_err
);

    localparam int NRAM  = NUM_LINES - 1;
    localparam int COL_W = $clog2(IMG_COL);
    localparam int ROW_W = $clog2(IMG_ROW);
    localparam int PTR_W = cnt_w(NRAM);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_COL - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_ROW - 1);
    localparam logic [ROW_W-1:0] ROW_FILLD = ROW_W'(NUM_LINES - 2);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NRAM - 1);

`ifdef IMG_LINEWIN_BORDER_REPLICATE_EN
    localparam state_t START_ST = ST_STREAM;
`else
    localparam state_t START_ST = ST_FILL;
`endif

    state_t            state, state_nxt;
    logic              fv_q, fv_rise, fv_fall;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [PTR_W-1:0]  wr_ptr, wr_ptr_q;
    logic              accept, emit, overflow, col_wrap, start;
    logic [DATA_W-1:0] pix_q;
    logic [DATA_W-1:0] ram_q [NRAM];
    logic [NUM_LINES*DATA_W-1:0] taps;

    assign fv_rise  = frame_valid & ~fv_q;
    assign fv_fall  = ~frame_valid & fv_q;
    assign start    = (state == ST_IDLE) && fv_rise;
    assign col_wrap = accept && (col == COL_LAST);

    // State register. fv_q resets high so a frame still in flight after reset is not
    // mistaken for a fresh rising edge.
    always_ff @(posedge cmos_pclk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            fv_q  <= 1'b1;
        end else begin
            state <= state_nxt;
            fv_q  <= frame_valid;
        end
    end

    always_comb begin
        state_nxt = state;
        if (fv_fall) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (fv_rise) state_nxt = START_ST;
                ST_FILL:   if (col_wrap && row == ROW_FILLD) state_nxt = ST_STREAM;
                ST_STREAM: if (col_wrap && row == ROW_LAST) state_nxt = ST_DONE;
                ST_DONE:   state_nxt = ST_DONE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        accept   = 1'b0;
        overflow = 1'b0;
        emit     = 1'b0;
        case (state)
            ST_FILL:   accept = pix_en;
            ST_STREAM: begin
                accept = pix_en;
                emit   = pix_en;
            end
            ST_DONE:   overflow = pix_en;
            default:   ;
        endcase
    end

    always_ff @(posedge cmos_pclk) begin
        if (!rst_n) begin
            col    <= '0;
            row    <= '0;
            wr_ptr <= '0;
        end else if (start) begin
            col    <= '0;
            row    <= '0;
            wr_ptr <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col    <= '0;
                row    <= (row == ROW_LAST) ? '0 : row + 1'b1;
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Short frames are those still collecting pixels when frame_valid drops.
    always_ff @(posedge cmos_pclk) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else if (start) begin
            frame_err <= 1'b0;
        end else if (overflow || (fv_fall && (state == ST_FILL || state == ST_STREAM))) begin
            frame_err <= 1'b1;
        end
    end

    always_ff @(posedge cmos_pclk) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            win_sol   <= 1'b0;
            win_eol   <= 1'b0;
            win_eof   <= 1'b0;
            win_col   <= '0;
            win_row   <= '0;
            wr_ptr_q  <= '0;
        end else begin
            win_valid <= emit;
            win_sol   <= emit && (col == '0);
            win_eol   <= emit && (col == COL_LAST);
            win_eof   <= emit && (col == COL_LAST) && (row == ROW_LAST);
            if (emit) begin
                win_col  <= col;
                win_row  <= row;
                wr_ptr_q <= wr_ptr;
            end
        end
    end

    // Current-line tap travels alongside the synchronous RAM read.
    always_ff @(posedge cmos_pclk) begin
        if (accept) pix_q <= pix_in;
    end

    for (genvar g = 0; g < NRAM; g++) begin : g_ram
        img_line_ram #(
            .DEPTH (IMG_COL),
            .WIDTH (DATA_W)
        ) u_ram (
            .cmos_pclk (cmos_pclk),
            .wr_en     (accept && (wr_ptr == PTR_W'(g))),
            .wr_addr   (col),
            .wr_data   (pix_in),
            .rd_en     (accept),
            .rd_addr   (col),
            .rd_data   (ram_q[g])
        );
    end

    // RAM[wr_ptr] holds the oldest line; the rest follow in ring order.
    always_comb begin
        logic [PTR_W-1:0] sel;
        sel  = '0;
        taps = '0;
        taps[(NUM_LINES-1)*DATA_W +: DATA_W] = pix_q;
        for (int i = 0; i < NRAM; i++) begin
            sel = PTR_W'(tap_ram_idx(int'(wr_ptr_q), i, NRAM));
            taps[i*DATA_W +: DATA_W] = ram_q[sel];
`ifdef IMG_LINEWIN_BORDER_REPLICATE_EN
            // Lines above row 0 repeat line 0, which is the live pixel while on row 0.
            if (int'(win_row) + i < NRAM)
                taps[i*DATA_W +: DATA_W] = (win_row == '0) ? pix_q : ram_q[0];
`endif
        end
    end

    assign win_data = win_valid ? taps : '0;

endmodule

// File: tb/tb_img_line_window.sv
// Scoreboard bench for img_line_window: default-size instance plus a 5-line, 16-column instance.
module tb_img_line_window;

    localparam int DW  = 16;
    localparam int NL  = 3;
    localparam int NC  = 512;
    localparam int NR  = 8;
    localparam int NL5 = 5;
    localparam int NC5 = 16;
    localparam int NR5 = 8;
`ifdef IMG_LINEWIN_BORDER_REPLICATE_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    typedef struct {
        logic [127:0] data;
        int           col;
        int           row;
        logic [2:0]   flags;
        longint       cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              frame_valid, pix_en;
    logic [DW-1:0]     pix_in;
    logic [NL*DW-1:0]  win_data;
    logic              win_valid, win_sol, win_eol, win_eof, frame_err;
    logic [8:0]        win_col;
    logic [2:0]        win_row;

    logic              frame_valid5, pix_en5;
    logic [DW-1:0]     pix_in5;
    logic [NL5*DW-1:0] win_data5;
    logic              win_valid5, win_sol5, win_eol5, win_eof5, frame_err5;
    logic [3:0]        win_col5;
    logic [2:0]        win_row5;

    exp_t         sb[$];
    exp_t         sb5[$];
    exp_t         em, em5;
    int           checks = 0;
    int           errors = 0;
    longint       cyc = 0;
    int           win_cnt = 0, eof_cnt = 0, win_cnt5 = 0;
    bit           first_seen = 1'b0;
    logic [127:0] first_win = '0;
    logic [127:0] probe5 [NR5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    img_line_window #(.DATA_W(DW), .IMG_COL(NC), .IMG_ROW(NR), .NUM_LINES(NL)) dut (
        .cmos_pclk (clk), .rst_n (rst_n), .frame_valid (frame_valid),
        .pix_in (pix_in), .pix_en (pix_en), .win_data (win_data),
        .win_valid (win_valid), .win_col (win_col), .win_row (win_row),
        .win_sol (win_sol), .win_eol (win_eol), .win_eof (win_eof),
        .frame_err (frame_err)
    );

    img_line_window #(.DATA_W(DW), .IMG_COL(NC5), .IMG_ROW(NR5), .NUM_LINES(NL5)) dut5 (
        .cmos_pclk (clk), .rst_n (rst_n), .frame_valid (frame_valid5),
        .pix_in (pix_in5), .pix_en (pix_en5), .win_data (win_data5),
        .win_valid (win_valid5), .win_col (win_col5), .win_row (win_row5),
        .win_sol (win_sol5), .win_eol (win_eol5), .win_eof (win_eof5),
        .frame_err (frame_err5)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Tap i (0 = oldest) of the window at (r,c); lines above row 0 replicate row 0.
    function automatic logic [127:0] model_win(input int nl, input int mult, input int r, input int c);
        logic [127:0] d;
        int l;
        d = '0;
        for (int i = 0; i < nl; i++) begin
            l = r - (nl - 1) + i;
            if (l < 0) l = 0;
            d[i*DW +: DW] = DW'(l * mult + c);
        end
        return d;
    endfunction

    function automatic bit emits(input int nl, input int r);
        return BORDER || (r >= nl - 1);
    endfunction

    function automatic int exp_wins(input int nl, input int nc, input int rows);
        int n;
        n = BORDER ? rows : rows - (nl - 1);
        return (n > 0) ? n * nc : 0;
    endfunction

    // Monitors: pop and compare on every presented window.
    always @(negedge clk) begin
        if (win_valid) begin
            if (sb.size() == 0) begin
                check("unexpected win_valid", 128'(win_valid), 128'd0);
            end else begin
                em = sb.pop_front();
                check("win_data", 128'(win_data), em.data);
                check("win_col/row", 128'({win_col, win_row}), 128'({em.col[8:0], em.row[2:0]}));
                check("sol/eol/eof", 128'({win_sol, win_eol, win_eof}), 128'(em.flags));
                check("latency", 128'(cyc), 128'(em.cyc));
                win_cnt++;
                if (win_eof) eof_cnt++;
                if (!first_seen) first_win = 128'(win_data);
                first_seen = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (win_valid5) begin
            if (sb5.size() == 0) begin
                check("unexpected win_valid5", 128'(win_valid5), 128'd0);
            end else begin
                em5 = sb5.pop_front();
                check("win_data5", 128'(win_data5), em5.data);
                check("win_col/row5", 128'({win_col5, win_row5}), 128'({em5.col[3:0], em5.row[2:0]}));
                check("sol/eol/eof5", 128'({win_sol5, win_eol5, win_eof5}), 128'(em5.flags));
                check("latency5", 128'(cyc), 128'(em5.cyc));
                win_cnt5++;
                if (win_col5 == 4'd3) probe5[win_row5] = 128'(win_data5);
            end
        end
    end

    task automatic send_row(input int r, input int c0, input int c1, input bit gaps, input bit push);
        exp_t e;
        for (int c = c0; c < c1; c++) begin
            @(negedge clk);
            pix_en = 1'b1;
            pix_in = DW'(r * NC + c);
            if (push && emits(NL, r)) begin
                e.data  = model_win(NL, NC, r, c);
                e.col   = c;
                e.row   = r;
                e.flags = {c == 0, c == NC - 1, (r == NR - 1) && (c == NC - 1)};
                e.cyc   = cyc + 1;
                sb.push_back(e);
            end
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    pix_en = 1'b0;
                end
            end
        end
        @(negedge clk);
        pix_en = 1'b0;
    endtask

    task automatic send_rows(input int rows, input bit gaps, input bit push);
        for (int r = 0; r < rows; r++) send_row(r, 0, NC, gaps, push);
    endtask

    task automatic start_frame();
        @(negedge clk);
        frame_valid = 1'b1;
        repeat (4) @(negedge clk);
        win_cnt = 0;
        eof_cnt = 0;
    endtask

    task automatic end_frame();
        @(negedge clk);
        pix_en      = 1'b0;
        frame_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic run_frame5();
        exp_t e;
        @(negedge clk);
        frame_valid5 = 1'b1;
        repeat (4) @(negedge clk);
        for (int r = 0; r < NR5; r++) begin
            for (int c = 0; c < NC5; c++) begin
                @(negedge clk);
                pix_en5 = 1'b1;
                pix_in5 = DW'(r * 256 + c);
                if (emits(NL5, r)) begin
                    e.data  = model_win(NL5, 256, r, c);
                    e.col   = c;
                    e.row   = r;
                    e.flags = {c == 0, c == NC5 - 1, (r == NR5 - 1) && (c == NC5 - 1)};
                    e.cyc   = cyc + 1;
                    sb5.push_back(e);
                end
            end
        end
        @(negedge clk);
        pix_en5      = 1'b0;
        frame_valid5 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, %0d windows pending", sb.size() + sb5.size());
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NR5; i++) probe5[i] = '0;
        rst_n = 1'b0; frame_valid = 1'b0; pix_en = 1'b0; pix_in = '0;
        frame_valid5 = 1'b0; pix_en5 = 1'b0; pix_in5 = '0;
        repeat (3) @(negedge clk);
        check("reset outputs", 128'({win_data, win_valid, win_col, win_row, win_sol, win_eol, win_eof, frame_err}), 128'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Test 1: continuous ramp frame.
        start_frame();
        send_rows(NR, 1'b0, 1'b1);
        end_frame();
        check("t1 window count", 128'(win_cnt), 128'(exp_wins(NL, NC, NR)));
        check("t1 eof count", 128'(eof_cnt), 128'd1);
        check("t1 frame_err", 128'(frame_err), 128'd0);
        check("t1 first window", first_win, BORDER ? 128'd0 : 128'h0400_0200_0000);

        // Test 2: random gaps in pix_en.
        start_frame();
        send_rows(NR, 1'b1, 1'b1);
        end_frame();
        check("t2 window count", 128'(win_cnt), 128'(exp_wins(NL, NC, NR)));
        check("t2 eof count", 128'(eof_cnt), 128'd1);

        // Test 3: short frame then a clean one.
        start_frame();
        send_rows(5, 1'b0, 1'b1);
        end_frame();
        check("t3 short frame_err", 128'(frame_err), 128'd1);
        check("t3 short eof count", 128'(eof_cnt), 128'd0);
        check("t3 short window count", 128'(win_cnt), 128'(exp_wins(NL, NC, 5)));
        start_frame();
        check("t3 frame_err cleared at start", 128'(frame_err), 128'd0);
        send_rows(NR, 1'b0, 1'b1);
        end_frame();
        check("t3 clean frame_err", 128'(frame_err), 128'd0);
        check("t3 clean eof count", 128'(eof_cnt), 128'd1);

        // Test 4: overflow pixels after the frame is complete.
        start_frame();
        send_rows(NR, 1'b0, 1'b1);
        check("t4 frame_err before overflow", 128'(frame_err), 128'd0);
        repeat (20) begin
            @(negedge clk);
            pix_en = 1'b1;
            @(negedge clk);
            pix_en = 1'b0;
        end
        check("t4 frame_err after overflow", 128'(frame_err), 128'd1);
        end_frame();
        check("t4 window count", 128'(win_cnt), 128'(exp_wins(NL, NC, NR)));

        // Test 5: one-cycle reset in the middle of row 4.
        start_frame();
        send_rows(4, 1'b0, 1'b1);
        send_row(4, 0, 100, 1'b0, 1'b1);
        @(negedge clk);
        rst_n  = 1'b0;
        pix_en = 1'b1;
        pix_in = 16'hBEEF;
        @(negedge clk);
        check("t5 outputs after reset", 128'({win_data, win_valid, win_col, win_row, win_sol, win_eol, win_eof, frame_err}), 128'd0);
        rst_n = 1'b1;
        send_row(4, 101, NC, 1'b0, 1'b0);
        for (int r = 5; r < NR; r++) send_row(r, 0, NC, 1'b0, 1'b0);
        end_frame();
        check("t5 aborted eof count", 128'(eof_cnt), 128'd0);
        start_frame();
        send_rows(NR, 1'b0, 1'b1);
        end_frame();
        check("t5 restart window count", 128'(win_cnt), 128'(exp_wins(NL, NC, NR)));
        check("t5 restart frame_err", 128'(frame_err), 128'd0);

        // Test 6: five-line instance.
        run_frame5();
        check("t6 window count", 128'(win_cnt5), 128'(exp_wins(NL5, NC5, NR5)));
        check("t6 frame_err", 128'(frame_err5), 128'd0);
        if (BORDER) begin
            check("t6 row0 col3 taps", probe5[0], 128'h0003_0003_0003_0003_0003);
            check("t6 row2 col3 taps", probe5[2], 128'h0203_0103_0003_0003_0003);
        end else begin
            check("t6 row4 col3 taps", probe5[4], 128'h0403_0303_0203_0103_0003);
            check("t6 row0 col3 absent", probe5[0], 128'd0);
        end

        check("scoreboard drained", 128'(sb.size()), 128'd0);
        check("scoreboard5 drained", 128'(sb5.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
